// File: rtl/lane_step_pkg.sv
// lane_step_pkg: shared types and helpers for the lane step engine.
//   lane_step_state_e : sweep controller states (IDLE, SWEEP, DONE).
//   lane_step_add     : unsigned add at a fixed maximum width with the carry
//                       kept in the extra top bit. Callers zero-extend their
//                       operands to LANE_STEP_MAX_W bits and truncate the
//                       result back to WIDTH+1 bits.
package lane_step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } lane_step_state_e;

  localparam int LANE_STEP_MAX_W = 64;

  function automatic logic [LANE_STEP_MAX_W:0] lane_step_add(
    input logic [LANE_STEP_MAX_W-1:0] x,
    input logic [LANE_STEP_MAX_W-1:0] y
  );
    return {1'b0, x} + {1'b0, y};
  endfunction

endpackage

// File: rtl/lane_step_sat_add.sv
// lane_step_sat_add: combinational WIDTH-bit adder shared by all lanes.
// Ports:
//   x, y  in  WIDTH : addends
//   sum   out WIDTH : result (wrapped, or saturated on carry)
//   carry out 1     : carry out of bit WIDTH-1
// Build option: define LANE_STEP_SAT_EN to clamp carried sums to all-ones;
// otherwise sums wrap modulo 2^WIDTH. The carry is reported either way.
module lane_step_sat_add
  import lane_step_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full;

  // The package helper works at a fixed wide width; only WIDTH+1 bits matter.
  assign full  = (WIDTH+1)'(lane_step_add(LANE_STEP_MAX_W'(x), LANE_STEP_MAX_W'(y)));
  assign carry = full[WIDTH];

`ifdef LANE_STEP_SAT_EN
  assign sum = carry ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
  assign sum = full[WIDTH-1:0];
`endif

endmodule

// File: rtl/lane_step_engine.sv
// lane_step_engine: sweeps LANES registers, one lane per cycle.
//   Lane 0 is loaded from the captured load value; lanes 1..LANES-1 get
//   (own value + STEP) in mode 0 or (captured operand + STEP) in mode 1.
// Ports:
//   clk      in  1            : rising-edge clock
//   rst      in  1            : asynchronous active-high reset
//   start    in  1            : sweep request, accepted only when idle
//   mode     in  1            : 0 self-add, 1 operand-add (captured at accept)
//   load_val in  WIDTH        : lane 0 value (captured at accept)
//   b        in  LANES*WIDTH  : per-lane operands, lane i at [i*WIDTH +: WIDTH]
//   a        out LANES*WIDTH  : lane registers, same packing as b
//   busy     out 1            : high while sweeping and in the done cycle
//   done     out 1            : one-cycle pulse after the last lane write
//   ovf      out 1            : sticky carry flag for the current sweep
// Build option: LANE_STEP_SAT_EN (see lane_step_sat_add) selects saturating
// lane additions instead of wrapping ones.
module lane_step_engine
  import lane_step_pkg::*;
#(
  parameter int LANES = 5,
  parameter int WIDTH = 8,
  parameter int STEP  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [WIDTH-1:0]       load_val,
  input  logic [LANES*WIDTH-1:0] b,
  output logic [LANES*WIDTH-1:0] a,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf
);

  localparam int               IW     = $clog2(LANES);
  localparam logic [IW-1:0]    LAST   = IW'(LANES - 1);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  lane_step_state_e state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic             accept;

  logic                   mode_snap;
  logic [WIDTH-1:0]       load_snap;
  logic [LANES*WIDTH-1:0] b_snap;

  logic [LANES*WIDTH-1:0] a_nxt;
  logic                   ovf_nxt;
  int                     base;
  logic [WIDTH-1:0]       opnd;
  logic [WIDTH-1:0]       sum;
  logic                   carry;

  // Controller: next state, sweep index and handshake outputs
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept    = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
          accept    = 1'b1;
        end
      end
      SWEEP: begin
        if (idx == LAST) begin
          state_nxt = DONE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single shared adder; the sweep index picks which lane feeds it
  assign base = int'(idx) * WIDTH;
  assign opnd = mode_snap ? b_snap[base +: WIDTH] : a[base +: WIDTH];

  lane_step_sat_add #(
    .WIDTH(WIDTH)
  ) u_add (
    .x    (opnd),
    .y    (STEP_W),
    .sum  (sum),
    .carry(carry)
  );

  // Next lane-array value: only the indexed lane may change
  always_comb begin
    a_nxt   = a;
    ovf_nxt = ovf;
    if (accept) begin
      ovf_nxt = 1'b0;
    end else if (state == SWEEP) begin
      if (idx == '0) begin
        a_nxt[WIDTH-1:0] = load_snap;
      end else begin
        a_nxt[base +: WIDTH] = sum;
        if (carry) ovf_nxt = 1'b1;
      end
    end
  end

  // Registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a         <= '0;
      ovf       <= 1'b0;
      mode_snap <= 1'b0;
      load_snap <= '0;
      b_snap    <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      a     <= a_nxt;
      ovf   <= ovf_nxt;
      if (accept) begin
        mode_snap <= mode;
        load_snap <= load_val;
        b_snap    <= b;
      end
    end
  end

endmodule

// File: doc/lane_step_engine.md
# lane_step_engine

Parametrised multi-lane register updater that sequentially sweeps an array of `LANES` registers. Lane 0 is loaded with a captured value. Every other lane is advanced by a constant step, either from its own current value or from a captured per-lane operand. The sweep runs one lane per cycle under a start/busy/done handshake. It sits beside datapath blocks that need a lint-clean, deterministic alternative to whole-array loop updates inside a single clocked process.

## Interface
- `LANES`, default 5: number of lanes; minimum 2.
- `WIDTH`, default 8: bits per lane.
- `STEP`, default 5: constant increment; must fit in `WIDTH` bits.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: request a sweep; accepted only in IDLE.
- `mode`  in  1: 0 = self-add (`a[i] + STEP`), 1 = operand-add (`b[i] + STEP`); captured at accept.
- `load_val`  in  WIDTH: value for lane 0; captured at accept.
- `b`  in  LANES*WIDTH: per-lane operands, lane i at bits [i*WIDTH +: WIDTH]; captured at accept.
- `a`  out  LANES*WIDTH: lane registers, same packing as `b`.
- `busy`  out  1: high in SWEEP and DONE.
- `done`  out  1: one-cycle pulse after the last lane is written.
- `ovf`  out  1: sticky; set if any lane addition carries out in the current sweep.

## Operation
- FSM states and transitions:
  - IDLE: `start`=1 goes to SWEEP with idx=0.
  - SWEEP: writes lane idx each cycle; at idx=LANES-1 goes to DONE.
  - DONE: goes unconditionally to IDLE.
- On accept:
  - latch `mode`, `load_val` and all of `b` into snapshot registers.
  - clear `ovf`.
  - live `b` and `load_val` are not observed after the accept edge.
- Lane writes during SWEEP:
  - idx=0: `a[0]` ← `load_val` snapshot; no arithmetic, no `ovf` contribution.
  - idx>0, mode 0: `a[idx]` ← `a[idx]` + STEP, using the value current at that cycle.
  - idx>0, mode 1: `a[idx]` ← `b_snap[idx]` + STEP.
- Arithmetic: computed in WIDTH+1 bits. Bit WIDTH is the carry. A carry sets `ovf`.
- Only lane idx changes in a given cycle. All other lanes hold.
- Per-lane selection is done with the sweep index in a combinational next-value process. The clocked process performs plain assignments only; it contains no loop statements.
- `start` while `busy`=1, including the DONE cycle, is ignored and not queued.
- Reset values, applied immediately on `rst` at any time including mid-sweep: `a`=0, `busy`=0, `done`=0, `ovf`=0, state IDLE, idx=0, snapshots 0.

## Timing
- Accept edge E0: `start`=1 sampled in IDLE.
- Lane k is written at edge E(k+1), for k = 0..LANES-1.
- After E(LANES): state DONE, `done`=1 for one cycle. After E(LANES+1): IDLE.
- `busy` is high from E0 to E(LANES+1): LANES+1 cycles.
- Minimum start-to-start spacing is LANES+2 cycles.
- `ovf` updates at the same edge as the lane write that carried.

## Configuration
- `LANE_STEP_SAT_EN` defined: lane additions with a carry saturate to 2^WIDTH-1; `ovf` is set.
- Not defined: lane additions wrap modulo 2^WIDTH; `ovf` is still set on carry.
- No other behaviour differs between the two builds.

## Structure
- Package `lane_step_pkg`:
  - `lane_step_state_e` enum (IDLE, SWEEP, DONE).
  - function `lane_step_add`, taking width via parameterised class or fixed max width with truncation at the call site.
- Sub-module `lane_step_sat_add`:
  - combinational WIDTH-bit adder producing the sum and carry.
  - the `LANE_STEP_SAT_EN` selection lives here.
  - one instance is shared by all lanes via the sweep index.

## Test plan
All cases use LANES=5, WIDTH=8, STEP=5.
- Reset: pulse `rst` → `a`=0 in all lanes, `busy`=0, `done`=0, `ovf`=0. Assert `rst` asynchronously between edges → outputs clear before the next edge.
- Mode 0 from reset: `load_val`=0x11, start → `a`={0x11,0x05,0x05,0x05,0x05} (lane 0 first). `done` is high only in the cycle after E5. `busy` is high for exactly 6 cycles.
- Mode 1: `b` lanes 1..4 = {10,20,30,40}. Change `b` to 0 one cycle after accept → `a` lanes 1..4 = {15,25,35,45} (snapshot is used).
- Overflow: preload lane 3 = 0xFE via mode 1 with `b[3]`=0xF9, then a mode 0 sweep → with `LANE_STEP_SAT_EN`, `a[3]`=0xFF and `ovf`=1; without it, `a[3]`=0x03 and `ovf`=1. The next accepted start clears `ovf`.
- Ignored start: pulse `start` at E2 and in the DONE cycle → no extra sweep. A start one cycle after DONE is accepted.
- Reset mid-sweep: assert `rst` after E2 → all lanes 0, IDLE. A start after deassertion runs a full, correct sweep.
